// File: rtl/core_run_ctrl.sv
// rtl/core_run_ctrl.sv - run-control sequencer for the single-cycle s_core datapath
module core_run_ctrl #(
    parameter int          IMEM_AW       = 8,
    parameter logic [31:0] DEFAULT_START = 32'h0000_0000,
    parameter logic [31:0] EBREAK_WORD   = 32'h0010_0073
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_host_valid,
    output logic               o_host_ready,
    input  logic [2:0]         i_host_cmd,
    input  logic [31:0]        i_host_addr,
    input  logic [31:0]        i_host_data,
    input  logic [31:0]        i_inst_data,
    input  logic               i_misaligned,
    output logic               o_pc_stall,
    output logic               o_pc_writing_first_addr,
    output logic [31:0]        o_pc_instr_start_addr,
    output logic               o_imem_write_en,
    output logic               o_imem_read_en,
    output logic [IMEM_AW-1:0] o_imem_addr,
    output logic [31:0]        o_imem_data,
    output logic               o_reg_rd_ctrl,
    output logic [4:0]         o_reg_load_addr,
    output logic [31:0]        o_reg_load_data,
    output logic               o_core_commit_en,
    output logic [2:0]         o_state,
    output logic [1:0]         o_halt_cause,
    output logic [31:0]        o_retired,
    output logic               o_cmd_err
);

    localparam logic [2:0] CMD_NOP       = 3'd0;
    localparam logic [2:0] CMD_WR_IMEM   = 3'd1;
    localparam logic [2:0] CMD_WR_REG    = 3'd2;
    localparam logic [2:0] CMD_SET_START = 3'd3;
    localparam logic [2:0] CMD_RUN       = 3'd4;
    localparam logic [2:0] CMD_HALT      = 3'd5;
    localparam logic [2:0] CMD_STEP      = 3'd6;

    localparam logic [1:0] CAUSE_NONE   = 2'd0;
    localparam logic [1:0] CAUSE_HOST   = 2'd1;
    localparam logic [1:0] CAUSE_EBREAK = 2'd2;
    localparam logic [1:0] CAUSE_FAULT  = 2'd3;

    typedef enum logic [2:0] {
        ST_HALTED = 3'd0,
        ST_START  = 3'd1,
        ST_RUN    = 3'd2,
        ST_STEP   = 3'd3
    } state_t;

    state_t      state;
    state_t      target;
    logic [31:0] step_cnt;

    logic accept;
    logic running;
    logic ebreak_hit;
    logic hit;
    logic host_halt;
    logic cmd_dropped;

    assign o_host_ready = 1'b1;
    assign accept       = i_host_valid & o_host_ready;
    assign running      = (state == ST_RUN) || (state == ST_STEP);
    assign ebreak_hit   = (i_inst_data == EBREAK_WORD);
    assign hit          = ebreak_hit | i_misaligned;
    assign host_halt    = accept && (i_host_cmd == CMD_HALT);
    // Anything but NOP/HALT is only legal while halted; code 7 is never legal.
    assign cmd_dropped  = accept && (i_host_cmd != CMD_NOP) && (i_host_cmd != CMD_HALT)
                          && ((state != ST_HALTED) || (i_host_cmd == 3'd7));

    // Stall must react in the same cycle the EBREAK/fault is fetched, so it is decoded, not registered.
    assign o_pc_stall              = !running || hit;
    assign o_core_commit_en        = running && !hit;
    assign o_imem_read_en          = (state != ST_HALTED);
    assign o_pc_writing_first_addr = (state == ST_START);
    assign o_state                 = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state                 <= ST_HALTED;
            target                <= ST_RUN;
            step_cnt              <= 32'd0;
            o_pc_instr_start_addr <= DEFAULT_START;
            o_halt_cause          <= CAUSE_NONE;
            o_retired             <= 32'd0;
            o_imem_write_en       <= 1'b0;
            o_imem_addr           <= '0;
            o_imem_data           <= 32'd0;
            o_reg_rd_ctrl         <= 1'b0;
            o_reg_load_addr       <= 5'd0;
            o_reg_load_data       <= 32'd0;
            o_cmd_err             <= 1'b0;
        end else begin
            o_imem_write_en <= 1'b0;
            o_reg_rd_ctrl   <= 1'b0;
            o_cmd_err       <= cmd_dropped;
            case (state)
                ST_HALTED: begin
                    if (accept) begin
                        case (i_host_cmd)
                            CMD_WR_IMEM: begin
                                o_imem_write_en <= 1'b1;
                                o_imem_addr     <= i_host_addr[IMEM_AW+1:2];
                                o_imem_data     <= i_host_data;
                            end
                            CMD_WR_REG: begin
                                o_reg_rd_ctrl   <= 1'b1;
                                o_reg_load_addr <= i_host_addr[4:0];
                                o_reg_load_data <= i_host_data;
                            end
                            CMD_SET_START: o_pc_instr_start_addr <= i_host_data;
                            CMD_HALT:      o_halt_cause <= CAUSE_HOST;
                            CMD_RUN: begin
                                state  <= ST_START;
                                target <= ST_RUN;
                            end
                            CMD_STEP: begin
                                state    <= ST_START;
                                target   <= ST_STEP;
                                step_cnt <= (i_host_data == 32'd0) ? 32'd1 : i_host_data;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_START: begin
                    o_halt_cause <= CAUSE_NONE;
                    o_retired    <= 32'd0;
                    state        <= target;
                    if (host_halt) begin
                        state        <= ST_HALTED;
                        o_halt_cause <= CAUSE_HOST;
                    end
                end
                ST_RUN, ST_STEP: begin
                    if (i_misaligned) begin
                        state        <= ST_HALTED;
                        o_halt_cause <= CAUSE_FAULT;
                    end else if (ebreak_hit) begin
                        state        <= ST_HALTED;
                        o_halt_cause <= CAUSE_EBREAK;
                    end else begin
                        o_retired <= o_retired + 32'd1;
                        if (host_halt) begin
                            state        <= ST_HALTED;
                            o_halt_cause <= CAUSE_HOST;
                        end
                        if (state == ST_STEP) begin
                            step_cnt <= step_cnt - 32'd1;
                            if (step_cnt == 32'd1) begin
                                state        <= ST_HALTED;
                                o_halt_cause <= CAUSE_EBREAK;
                            end
                        end
                    end
                end
                default: state <= ST_HALTED;
            endcase
        end
    end

endmodule

// File: tb/tb_core_run_ctrl.sv
// tb/tb_core_run_ctrl.sv - self-checking bench for core_run_ctrl with a tiny behavioural core
module tb_core_run_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_host_valid = 1'b0;
    logic        o_host_ready;
    logic [2:0]  i_host_cmd = 3'd0;
    logic [31:0] i_host_addr = 32'd0;
    logic [31:0] i_host_data = 32'd0;
    logic [31:0] i_inst_data;
    logic        i_misaligned = 1'b0;
    logic        o_pc_stall;
    logic        o_pc_writing_first_addr;
    logic [31:0] o_pc_instr_start_addr;
    logic        o_imem_write_en;
    logic        o_imem_read_en;
    logic [7:0]  o_imem_addr;
    logic [31:0] o_imem_data;
    logic        o_reg_rd_ctrl;
    logic [4:0]  o_reg_load_addr;
    logic [31:0] o_reg_load_data;
    logic        o_core_commit_en;
    logic [2:0]  o_state;
    logic [1:0]  o_halt_cause;
    logic [31:0] o_retired;
    logic        o_cmd_err;

    always #5 clk = ~clk;

    core_run_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .i_host_valid(i_host_valid), .o_host_ready(o_host_ready),
        .i_host_cmd(i_host_cmd), .i_host_addr(i_host_addr), .i_host_data(i_host_data),
        .i_inst_data(i_inst_data), .i_misaligned(i_misaligned),
        .o_pc_stall(o_pc_stall), .o_pc_writing_first_addr(o_pc_writing_first_addr),
        .o_pc_instr_start_addr(o_pc_instr_start_addr),
        .o_imem_write_en(o_imem_write_en), .o_imem_read_en(o_imem_read_en),
        .o_imem_addr(o_imem_addr), .o_imem_data(o_imem_data),
        .o_reg_rd_ctrl(o_reg_rd_ctrl), .o_reg_load_addr(o_reg_load_addr),
        .o_reg_load_data(o_reg_load_data), .o_core_commit_en(o_core_commit_en),
        .o_state(o_state), .o_halt_cause(o_halt_cause), .o_retired(o_retired),
        .o_cmd_err(o_cmd_err)
    );

    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] JLOOP  = 32'h0000_006F;

    int checks = 0;
    int fails  = 0;

    // Minimal single-cycle core: ADDI and JAL-to-self only, enough to exercise the controller.
    logic [31:0] mem  [256];
    logic [31:0] regs [32];
    logic [31:0] pc;
    logic [31:0] cur;

    assign i_inst_data = mem[pc[9:2]];

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
            pc <= 32'd0;
        end else begin
            if (o_imem_write_en) mem[o_imem_addr] <= o_imem_data;
            if (o_reg_rd_ctrl && o_reg_load_addr != 5'd0) regs[o_reg_load_addr] <= o_reg_load_data;
            if (o_pc_writing_first_addr) pc <= o_pc_instr_start_addr;
            else if (!o_pc_stall) begin
                cur = mem[pc[9:2]];
                if (o_core_commit_en && cur[6:0] == 7'h13 && cur[14:12] == 3'd0 && cur[11:7] != 5'd0)
                    regs[cur[11:7]] <= regs[cur[19:15]] + {{20{cur[31]}}, cur[31:20]};
                if (cur[6:0] != 7'h6F) pc <= pc + 32'd4;
            end
        end
    end

    function automatic logic [31:0] addi(input int rd, input int rs1, input logic [11:0] imm);
        logic [31:0] r;
        logic [31:0] d;
        logic [31:0] s;
        d = rd;
        s = rs1;
        r = {imm, s[4:0], 3'b000, d[4:0], 7'h13};
        return r;
    endfunction

    // Present one command for one cycle; returns on the negedge where its registered effect is visible.
    task automatic drive(input logic [2:0] cmd, input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        i_host_valid = 1'b1;
        i_host_cmd   = cmd;
        i_host_addr  = addr;
        i_host_data  = data;
        @(negedge clk);
        i_host_valid = 1'b0;
        i_host_cmd   = 3'd0;
    endtask

    task automatic wait_halted(input int maxc, input string nm);
        int n;
        n = 0;
        while (o_state !== 3'd0 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        checks++; if (o_state !== 3'd0) begin fails++; $display("FAIL %s_timeout state=%0d expected=0", nm, o_state); end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (o_state !== 3'd0) begin fails++; $display("FAIL reset_state got=%0d exp=0", o_state); end
        checks++; if (o_pc_stall !== 1'b1) begin fails++; $display("FAIL reset_stall got=%b exp=1", o_pc_stall); end
        checks++; if (o_pc_instr_start_addr !== 32'd0) begin fails++; $display("FAIL reset_start got=%h exp=0", o_pc_instr_start_addr); end
        checks++; if (o_retired !== 32'd0 || o_halt_cause !== 2'd0) begin fails++; $display("FAIL reset_counters retired=%h cause=%0d exp=0/0", o_retired, o_halt_cause); end
        checks++; if ({o_imem_write_en, o_reg_rd_ctrl, o_cmd_err, o_core_commit_en, o_imem_read_en, o_pc_writing_first_addr} !== 6'd0)
            begin fails++; $display("FAIL reset_strobes got=%b exp=000000", {o_imem_write_en, o_reg_rd_ctrl, o_cmd_err, o_core_commit_en, o_imem_read_en, o_pc_writing_first_addr}); end
        checks++; if (o_reg_load_data !== 32'd0 || o_imem_data !== 32'd0) begin fails++; $display("FAIL reset_data load=%h imem=%h exp=0", o_reg_load_data, o_imem_data); end
        checks++; if (o_host_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b exp=1", o_host_ready); end
        rst_n = 1'b1;
    endtask

    task automatic test_imem_load;
        logic [31:0] prog [3];
        prog[0] = addi(1, 0, 12'd5);
        prog[1] = addi(1, 1, 12'd1);
        prog[2] = EBREAK;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            i_host_valid = 1'b1; i_host_cmd = 3'd1; i_host_addr = i * 4; i_host_data = prog[i];
            @(negedge clk);
            checks++; if (o_imem_write_en !== 1'b1 || o_imem_addr !== 8'(i) || o_imem_data !== prog[i])
                begin fails++; $display("FAIL imem_b2b_%0d we=%b addr=%0d data=%h exp=1/%0d/%h", i, o_imem_write_en, o_imem_addr, o_imem_data, i, prog[i]); end
        end
        i_host_valid = 1'b0;
        @(negedge clk);
        checks++; if (o_imem_write_en !== 1'b0) begin fails++; $display("FAIL imem_we_drop got=%b exp=0", o_imem_write_en); end
    endtask

    task automatic test_run_ebreak;
        drive(3'd4, 32'd0, 32'd0);
        checks++; if (o_state !== 3'd1 || o_pc_writing_first_addr !== 1'b1 || o_pc_instr_start_addr !== 32'd0 || o_imem_read_en !== 1'b1)
            begin fails++; $display("FAIL run_start state=%0d wfa=%b start=%h rd=%b exp=1/1/0/1", o_state, o_pc_writing_first_addr, o_pc_instr_start_addr, o_imem_read_en); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (o_state !== 3'd2 || o_core_commit_en !== 1'b1 || o_pc_stall !== 1'b0)
                begin fails++; $display("FAIL run_cycle_%0d state=%0d commit=%b stall=%b exp=2/1/0", i, o_state, o_core_commit_en, o_pc_stall); end
        end
        @(negedge clk);
        checks++; if (o_core_commit_en !== 1'b0 || o_pc_stall !== 1'b1)
            begin fails++; $display("FAIL ebreak_cycle commit=%b stall=%b exp=0/1", o_core_commit_en, o_pc_stall); end
        @(negedge clk);
        checks++; if (o_state !== 3'd0 || o_halt_cause !== 2'd2 || o_retired !== 32'd2 || regs[1] !== 32'd6)
            begin fails++; $display("FAIL ebreak_halt state=%0d cause=%0d retired=%0d x1=%0d exp=0/2/2/6", o_state, o_halt_cause, o_retired, regs[1]); end
    endtask

    task automatic test_wr_reg;
        logic [31:0] d;
        logic [4:0]  a;
        drive(3'd2, 32'd3, 32'hDEAD_BEEF);
        checks++; if (o_reg_rd_ctrl !== 1'b1 || o_reg_load_addr !== 5'd3 || o_reg_load_data !== 32'hDEAD_BEEF)
            begin fails++; $display("FAIL wr_reg ctrl=%b addr=%0d data=%h exp=1/3/deadbeef", o_reg_rd_ctrl, o_reg_load_addr, o_reg_load_data); end
        @(negedge clk);
        checks++; if (o_reg_rd_ctrl !== 1'b0) begin fails++; $display("FAIL wr_reg_one_cycle got=%b exp=0", o_reg_rd_ctrl); end
        for (int i = 0; i < 3; i++) begin
            d = $urandom;
            a = 5'($urandom_range(0, 31));
            drive(3'd2, {27'd0, a}, d);
            checks++; if (o_reg_rd_ctrl !== 1'b1 || o_reg_load_addr !== a || o_reg_load_data !== d)
                begin fails++; $display("FAIL wr_reg_rand_%0d ctrl=%b addr=%0d data=%h exp=1/%0d/%h", i, o_reg_rd_ctrl, o_reg_load_addr, o_reg_load_data, a, d); end
        end
        drive(3'd2, 32'd2, 32'd0);
    endtask

    task automatic test_step;
        int n;
        for (int i = 0; i < 16; i++) drive(3'd1, 32'h10 + i * 4, addi(2, 2, 12'd1));
        drive(3'd1, 32'h50, EBREAK);
        drive(3'd3, 32'd0, 32'h10);
        checks++; if (o_pc_instr_start_addr !== 32'h10) begin fails++; $display("FAIL set_start got=%h exp=10", o_pc_instr_start_addr); end
        drive(3'd6, 32'd0, 32'd0);
        wait_halted(50, "step0");
        checks++; if (o_retired !== 32'd1 || o_halt_cause !== 2'd2 || regs[2] !== 32'd1)
            begin fails++; $display("FAIL step0 retired=%0d cause=%0d x2=%0d exp=1/2/1", o_retired, o_halt_cause, regs[2]); end
        n = $urandom_range(2, 8);
        drive(3'd6, 32'd0, n);
        wait_halted(50, "stepn");
        checks++; if (o_retired !== 32'(n) || o_halt_cause !== 2'd2 || regs[2] !== 32'(1 + n))
            begin fails++; $display("FAIL stepn retired=%0d cause=%0d x2=%0d exp=%0d/2/%0d", o_retired, o_halt_cause, regs[2], n, 1 + n); end
        drive(3'd5, 32'd0, 32'd0);
        checks++; if (o_halt_cause !== 2'd1 || o_state !== 3'd0) begin fails++; $display("FAIL halt_idle cause=%0d state=%0d exp=1/0", o_halt_cause, o_state); end
    endtask

    task automatic test_random_program;
        for (int it = 0; it < 3; it++) begin
            int n;
            logic [11:0] imm;
            logic [31:0] sum;
            n = $urandom_range(1, 12);
            sum = 32'd0;
            for (int i = 0; i < n; i++) begin
                imm = 12'($urandom_range(0, 4095));
                sum = sum + {{20{imm[11]}}, imm};
                drive(3'd1, 32'h100 + i * 4, addi(5, (i == 0) ? 0 : 5, imm));
            end
            drive(3'd1, 32'h100 + n * 4, EBREAK);
            drive(3'd3, 32'd0, 32'h100);
            drive(3'd4, 32'd0, 32'd0);
            wait_halted(100, "rand_prog");
            checks++; if (o_retired !== 32'(n) || o_halt_cause !== 2'd2 || regs[5] !== sum)
                begin fails++; $display("FAIL rand_prog_%0d retired=%0d cause=%0d x5=%h exp=%0d/2/%h", it, o_retired, o_halt_cause, regs[5], n, sum); end
        end
    endtask

    task automatic test_cmd_err_loop;
        logic [31:0] r0;
        drive(3'd1, 32'h80, JLOOP);
        drive(3'd3, 32'd0, 32'h80);
        drive(3'd4, 32'd0, 32'd0);
        repeat (3) @(negedge clk);
        r0 = o_retired;
        repeat (5) @(negedge clk);
        checks++; if (o_retired !== r0 + 32'd5) begin fails++; $display("FAIL retired_rate got=%0d exp=%0d", o_retired, r0 + 32'd5); end
        drive(3'd1, 32'd0, 32'hCAFE_F00D);
        checks++; if (o_cmd_err !== 1'b1 || o_imem_write_en !== 1'b0 || o_state !== 3'd2)
            begin fails++; $display("FAIL wr_in_run err=%b we=%b state=%0d exp=1/0/2", o_cmd_err, o_imem_write_en, o_state); end
        @(negedge clk);
        checks++; if (o_cmd_err !== 1'b0 || mem[0] !== 32'h0050_0093)
            begin fails++; $display("FAIL cmd_err_pulse err=%b mem0=%h exp=0/00500093", o_cmd_err, mem[0]); end
        drive(3'd3, 32'd0, 32'h44);
        checks++; if (o_cmd_err !== 1'b1 || o_pc_instr_start_addr !== 32'h80)
            begin fails++; $display("FAIL start_in_run err=%b start=%h exp=1/80", o_cmd_err, o_pc_instr_start_addr); end
        drive(3'd5, 32'd0, 32'd0);
        checks++; if (o_state !== 3'd0 || o_halt_cause !== 2'd1 || o_pc_stall !== 1'b1 || o_cmd_err !== 1'b0)
            begin fails++; $display("FAIL halt_run state=%0d cause=%0d stall=%b err=%b exp=0/1/1/0", o_state, o_halt_cause, o_pc_stall, o_cmd_err); end
    endtask

    task automatic test_misaligned;
        logic [31:0] r0;
        drive(3'd4, 32'd0, 32'd0);
        repeat (2) @(negedge clk);
        r0 = o_retired;
        i_misaligned = 1'b1;
        #1;
        checks++; if (o_core_commit_en !== 1'b0 || o_pc_stall !== 1'b1)
            begin fails++; $display("FAIL misalign_gate commit=%b stall=%b exp=0/1", o_core_commit_en, o_pc_stall); end
        @(negedge clk);
        i_misaligned = 1'b0;
        checks++; if (o_state !== 3'd0 || o_halt_cause !== 2'd3 || o_retired !== r0)
            begin fails++; $display("FAIL misalign_halt state=%0d cause=%0d retired=%0d exp=0/3/%0d", o_state, o_halt_cause, o_retired, r0); end
        drive(3'd3, 32'd0, 32'h8);
        drive(3'd4, 32'd0, 32'd0);
        i_misaligned = 1'b1;
        @(negedge clk);
        @(negedge clk);
        i_misaligned = 1'b0;
        checks++; if (o_state !== 3'd0 || o_halt_cause !== 2'd3 || o_retired !== 32'd0)
            begin fails++; $display("FAIL fault_over_ebreak state=%0d cause=%0d retired=%0d exp=0/3/0", o_state, o_halt_cause, o_retired); end
    endtask

    task automatic test_reset_mid_run;
        drive(3'd3, 32'd0, 32'h80);
        drive(3'd4, 32'd0, 32'd0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (o_state !== 3'd0 || o_retired !== 32'd0 || o_pc_stall !== 1'b1 || o_pc_instr_start_addr !== 32'd0 || o_halt_cause !== 2'd0)
            begin fails++; $display("FAIL reset_mid_run state=%0d retired=%0d stall=%b start=%h cause=%0d exp=0/0/1/0/0", o_state, o_retired, o_pc_stall, o_pc_instr_start_addr, o_halt_cause); end
        rst_n = 1'b1;
        @(negedge clk);
        i_host_valid = 1'b1; i_host_cmd = 3'd2; i_host_addr = 32'd7; i_host_data = 32'h1234_5678;
        rst_n = 1'b0;
        @(negedge clk);
        i_host_valid = 1'b0;
        checks++; if (o_reg_rd_ctrl !== 1'b0 || o_reg_load_data !== 32'd0)
            begin fails++; $display("FAIL reset_cancels_strobe ctrl=%b data=%h exp=0/0", o_reg_rd_ctrl, o_reg_load_data); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_imem_load;
        test_run_ebreak;
        test_wr_reg;
        test_step;
        test_random_program;
        test_cmd_err_loop;
        test_misaligned;
        test_reset_mid_run;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
